// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - fetch, data and loader bus between processor side and memory_responder
// Addresses share the word width; only the low ADDR_W bits index the array.
interface memory_responder_if #(
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] Iaddress;
    logic [DATA_W-1:0] Instr_Out;
    logic [DATA_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWriteData;
    logic              MemWriteEnable;
    logic [DATA_W-1:0] MemReadData;
    logic              Load_Valid;
    logic [DATA_W-1:0] Load_Data;
    logic              Load_Last;
    logic              Load_Ready;
    logic              Cpu_Run;
    logic              Addr_Error;

    modport master (
        output Iaddress, MemAddress, MemWriteData, MemWriteEnable,
        output Load_Valid, Load_Data, Load_Last,
        input  Instr_Out, MemReadData, Load_Ready, Cpu_Run, Addr_Error
    );

    modport slave (
        input  Iaddress, MemAddress, MemWriteData, MemWriteEnable,
        input  Load_Valid, Load_Data, Load_Last,
        output Instr_Out, MemReadData, Load_Ready, Cpu_Run, Addr_Error
    );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - shared word array behind fetch and data ports, filled by a loader FSM
// Reads are combinational; the single write port is shared by the loader (LOAD) and data port (RUN).
module memory_responder #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 12,
    parameter int MAX_LOAD = 4096
) (
    input  logic                Clock,
    input  logic                Reset,
    memory_responder_if.slave   bus
);
    localparam int PTR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_LOAD = 2'b01,
        S_RUN  = 2'b10
    } state_e;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              run;
    logic              i_oor, d_oor;
    logic              load_xfer;
    logic [PTR_W-1:0]  ptr_inc;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign run       = (state_q == S_RUN);
    assign i_oor     = |bus.Iaddress[DATA_W-1:ADDR_W];
    assign d_oor     = |bus.MemAddress[DATA_W-1:ADDR_W];
    assign load_xfer = (state_q == S_LOAD) && ready_q && bus.Load_Valid;
    assign ptr_inc   = ptr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = bus.MemAddress[ADDR_W-1:0];
        wr_data = bus.MemWriteData;
        case (state_q)
            S_LOAD: begin
                if (load_xfer) begin
                    ptr_d   = ptr_inc;
                    wr_en   = 1'b1;
                    wr_addr = ptr_q[ADDR_W-1:0];
                    wr_data = bus.Load_Data;
                    if (bus.Load_Last || (ptr_inc == PTR_W'(MAX_LOAD))) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (i_oor || d_oor) begin
                    err_d = 1'b1;
                end
                if (bus.MemWriteEnable && !d_oor) begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        // Ready is registered so it stays low while reset is held and rises one edge later.
        ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_LOAD;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array contents deliberately survive reset so a partial reload keeps untouched words.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign bus.Instr_Out   = (run && !i_oor) ? mem[bus.Iaddress[ADDR_W-1:0]]   : '0;
    assign bus.MemReadData = (run && !d_oor) ? mem[bus.MemAddress[ADDR_W-1:0]] : '0;
    assign bus.Load_Ready  = ready_q;
    assign bus.Cpu_Run     = run;
    assign bus.Addr_Error  = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder load, read, write and range checks
`timescale 1ns/1ps
module tb_memory_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_responder_if #(.DATA_W(20)) bus ();

    memory_responder #(
        .DATA_W  (20),
        .ADDR_W  (12),
        .MAX_LOAD(4)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [19:0] val;
        logic [19:0] addr;
        bit          is_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [19:0] obs;
    logic [19:0] model [0:4095];
    int          ld_ptr;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        bus.Load_Valid = 1'b0;
        bus.Load_Last = 1'b0;
        bus.Load_Data = '0;
        bus.MemWriteEnable = 1'b0;
        bus.MemWriteData = '0;
        bus.Iaddress = '0;
        bus.MemAddress = '0;
        ld_ptr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_load(input logic [19:0] d, input bit last, input bit expect_xfer);
        bus.Load_Valid = 1'b1;
        bus.Load_Data = d;
        bus.Load_Last = last;
        tick();
        bus.Load_Valid = 1'b0;
        bus.Load_Last = 1'b0;
        if (expect_xfer) begin
            model[ld_ptr] = d;
            ld_ptr++;
        end
    endtask

    task automatic probe(input logic [19:0] a);
        exp_t x;
        bus.Iaddress = a;
        bus.MemAddress = a;
        x.val = model[a[11:0]];
        x.addr = a;
        x.is_data = 1'b0;
        sb.push_back(x);
        x.is_data = 1'b1;
        sb.push_back(x);
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (bus.Cpu_Run !== 1'b0 || bus.Load_Ready !== 1'b0 || bus.Addr_Error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got run=%b ready=%b err=%b want 0 0 0", bus.Cpu_Run, bus.Load_Ready, bus.Addr_Error);
        end
        apply_reset();
        vectors++;
        if (bus.Load_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b want 0", bus.Load_Ready);
        end
        tick();
        vectors++;
        if (bus.Load_Ready !== 1'b1 || bus.Cpu_Run !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_edge: got ready=%b run=%b want 1 0", bus.Load_Ready, bus.Cpu_Run);
        end
    endtask

    task automatic test_load;
        logic [19:0] words [3];
        words[0] = 20'h0A001;
        words[1] = 20'h0B002;
        words[2] = 20'h0C003;
        for (int i = 0; i < 3; i++) begin
            drive_load(words[i], i == 2, 1'b1);
            vectors++;
            if (bus.Cpu_Run !== (i == 2)) begin
                miscompares++;
                $display("FAIL t1_cpu_run[%0d]: got %b want %b", i, bus.Cpu_Run, i == 2);
            end
        end
        for (int a = 0; a < 3; a++) begin
            probe(20'(a));
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL t1_read[%h,%b]: got %h want %h", e.addr, e.is_data, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_read_before_write;
        bus.MemAddress = 20'h00004;
        bus.MemWriteData = 20'h0D004;
        bus.MemWriteEnable = 1'b1;
        model[4] = 20'h0D004;
        tick();
        bus.MemAddress = 20'h00010;
        bus.MemWriteData = 20'h12345;
        model[16] = 20'h12345;
        tick();
        bus.MemWriteData = 20'hFFFFF;
        probe(20'h00010);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL t2_old_word[%b]: got %h want %h", e.is_data, obs, e.val);
            end
        end
        model[16] = 20'hFFFFF;
        tick();
        bus.MemWriteEnable = 1'b0;
        probe(20'h00010);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL t2_new_word[%b]: got %h want %h", e.is_data, obs, e.val);
            end
        end
    endtask

    task automatic test_out_of_range;
        bus.Iaddress = 20'h00000;
        bus.MemAddress = 20'h01000;
        bus.MemWriteData = 20'h55555;
        bus.MemWriteEnable = 1'b1;
        #1;
        vectors++;
        if (bus.MemReadData !== 20'h0 || bus.Addr_Error !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_oor_cycle: got data=%h err=%b want 00000 0", bus.MemReadData, bus.Addr_Error);
        end
        tick();
        bus.MemWriteEnable = 1'b0;
        probe(20'h00000);
        #1;
        vectors++;
        if (bus.Addr_Error !== 1'b1) begin
            miscompares++;
            $display("FAIL t3_err_set: got %b want 1", bus.Addr_Error);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL t3_mem0[%b]: got %h want %h", e.is_data, obs, e.val);
            end
        end
        bus.Iaddress = 20'h80000;
        #1;
        vectors++;
        if (bus.Instr_Out !== 20'h0) begin
            miscompares++;
            $display("FAIL t3_fetch_oor: got %h want 00000", bus.Instr_Out);
        end
        repeat (3) tick();
        bus.Iaddress = 20'h00000;
        vectors++;
        if (bus.Addr_Error !== 1'b1) begin
            miscompares++;
            $display("FAIL t3_err_sticky: got %b want 1", bus.Addr_Error);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.Cpu_Run !== 1'b0 || bus.Addr_Error !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_async_reset: got run=%b err=%b want 0 0", bus.Cpu_Run, bus.Addr_Error);
        end
        apply_reset();
        tick();
    endtask

    task automatic test_valid_gaps;
        bus.MemWriteEnable = 1'b1;
        bus.MemAddress = 20'h00002;
        bus.MemWriteData = 20'h77777;
        bus.Iaddress = 20'h80000;
        bus.Load_Valid = 1'b1;
        bus.Load_Data = 20'h11111;
        #1;
        vectors++;
        if (bus.Instr_Out !== 20'h0 || bus.MemReadData !== 20'h0) begin
            miscompares++;
            $display("FAIL t4_load_reads: got instr=%h data=%h want 0 0", bus.Instr_Out, bus.MemReadData);
        end
        tick();
        model[0] = 20'h11111;
        bus.Load_Valid = 1'b0;
        tick();
        vectors++;
        if (bus.Cpu_Run !== 1'b0 || bus.Load_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL t4_gap_state: got run=%b ready=%b want 0 1", bus.Cpu_Run, bus.Load_Ready);
        end
        bus.Load_Data = 20'h22222;
        bus.Load_Last = 1'b1;
        bus.Load_Valid = 1'b1;
        tick();
        model[1] = 20'h22222;
        bus.Load_Valid = 1'b0;
        bus.Load_Last = 1'b0;
        bus.MemWriteEnable = 1'b0;
        bus.MemAddress = 20'h00000;
        bus.Iaddress = 20'h00000;
        #1;
        vectors++;
        if (bus.Cpu_Run !== 1'b1 || bus.Load_Ready !== 1'b0 || bus.Addr_Error !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_run: got run=%b ready=%b err=%b want 1 0 0", bus.Cpu_Run, bus.Load_Ready, bus.Addr_Error);
        end
        for (int a = 0; a < 3; a++) begin
            probe(20'(a));
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL t4_read[%h,%b]: got %h want %h", e.addr, e.is_data, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load;
        apply_reset();
        tick();
        drive_load(20'h44441, 1'b0, 1'b1);
        drive_load(20'h44442, 1'b0, 1'b1);
        vectors++;
        if (bus.Cpu_Run !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_mid_load_run: got %b want 0", bus.Cpu_Run);
        end
        apply_reset();
        tick();
        drive_load(20'h33333, 1'b1, 1'b1);
        vectors++;
        if (bus.Cpu_Run !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_cpu_run: got %b want 1", bus.Cpu_Run);
        end
        for (int a = 0; a < 2; a++) begin
            probe(20'(a));
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL t5_read[%h,%b]: got %h want %h", e.addr, e.is_data, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_max_load;
        apply_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_load(20'h60001 + 20'(i), 1'b0, 1'b1);
            vectors++;
            if (bus.Cpu_Run !== (i == 3)) begin
                miscompares++;
                $display("FAIL t6_cpu_run[%0d]: got %b want %b", i, bus.Cpu_Run, i == 3);
            end
        end
        vectors++;
        if (bus.Load_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_ready: got %b want 0", bus.Load_Ready);
        end
        drive_load(20'h60005, 1'b0, 1'b0);
        vectors++;
        if (bus.Cpu_Run !== 1'b1 || bus.Load_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_fifth_ignored: got run=%b ready=%b want 1 0", bus.Cpu_Run, bus.Load_Ready);
        end
        for (int a = 0; a < 5; a++) begin
            probe(20'(a));
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = e.is_data ? bus.MemReadData : bus.Instr_Out;
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL t6_read[%h,%b]: got %h want %h", e.addr, e.is_data, obs, e.val);
                end
            end
        end
    endtask

    initial begin
        bus.Load_Valid = 1'b0;
        bus.Load_Last = 1'b0;
        bus.Load_Data = '0;
        bus.MemWriteEnable = 1'b0;
        bus.MemWriteData = '0;
        bus.Iaddress = '0;
        bus.MemAddress = '0;
        test_reset();
        test_load();
        test_read_before_write();
        test_out_of_range();
        test_valid_gaps();
        test_reset_mid_load();
        test_max_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
